weightmemory_decode_stage: RTL and testbench

WEIGHTMEMORY_DECODE_STAGE -- requirements
Module: weightmemory_decode_stage

---
 rtl/weightmemory_decode_stage_if.sv | 31 +++
 rtl/weightmemory_decode_stage.sv | 89 ++++++++
 tb/tb_weightmemory_decode_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/weightmemory_decode_stage_if.sv
// weightmemory_decode_stage_if: read request, packed memory word and decoded-word handshake of the decode stage.
interface weightmemory_decode_stage_if #(
    parameter int N_I            = 512,
    parameter int WEIGHT_STAGGER = 8,
    parameter int TAGW           = 8
);
    localparam int EFFTRITS = N_I / WEIGHT_STAGGER;
    localparam int NUMDEC   = (EFFTRITS + 4) / 5;
    localparam int PHYSBITS = NUMDEC * 8;

    logic                    flush_i;
    logic                    rd_en_i;
    logic [TAGW-1:0]         rd_tag_i;
    logic                    in_ready_o;
    logic [PHYSBITS-1:0]     mem_rdata_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [2*EFFTRITS-1:0]   out_trits_o;
    logic [TAGW-1:0]         out_tag_o;
    logic                    decode_err_o;
    logic [15:0]             word_count_o;

    modport slave (
        input  flush_i, rd_en_i, rd_tag_i, mem_rdata_i, out_ready_i,
        output in_ready_o, out_valid_o, out_trits_o, out_tag_o, decode_err_o, word_count_o
    );
    modport master (
        output flush_i, rd_en_i, rd_tag_i, mem_rdata_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_trits_o, out_tag_o, decode_err_o, word_count_o
    );
endinterface

// File: rtl/weightmemory_decode_stage.sv
// weightmemory_decode_stage: decodes base-3 packed weight bytes (5 trits/byte) from a 1-cycle-latency memory into a 2-entry output FIFO.
module weightmemory_decode_stage #(
    parameter int N_I            = 512,
    parameter int WEIGHT_STAGGER = 8,
    parameter int TAGW           = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    weightmemory_decode_stage_if.slave    bus
);
    localparam int EFFTRITS = N_I / WEIGHT_STAGGER;
    localparam int NUMDEC   = (EFFTRITS + 4) / 5;
    localparam int PHYSBITS = NUMDEC * 8;

    logic                  inflight;
    logic [TAGW-1:0]       tag_q;
    logic [1:0]            count;
    logic                  rd_ptr, wr_ptr;
    logic                  err_q;
    logic [15:0]           wc_q;
    logic [2*EFFTRITS-1:0] trits_mem [2];
    logic [TAGW-1:0]       tag_mem [2];
    logic [2*EFFTRITS-1:0] dec_trits;
    logic [NUMDEC-1:0]     bad;
    logic                  accept, push, pop;

    // Readiness counts the in-flight read so the FIFO can never overflow.
    assign bus.in_ready_o   = (count + {1'b0, inflight}) < 2'd2;
    assign bus.out_valid_o  = count != 2'd0;
    assign bus.out_trits_o  = bus.out_valid_o ? trits_mem[rd_ptr] : '0;
    assign bus.out_tag_o    = bus.out_valid_o ? tag_mem[rd_ptr] : '0;
    assign bus.decode_err_o = err_q;
    assign bus.word_count_o = wc_q;

    assign accept = bus.rd_en_i & bus.in_ready_o & ~bus.flush_i;
    assign push   = inflight & ~bus.flush_i;
    assign pop    = bus.out_valid_o & bus.out_ready_i & ~bus.flush_i;

    for (genvar d = 0; d < NUMDEC; d++) begin : g_dec
        logic [7:0] b;
        assign b      = bus.mem_rdata_i[8*d +: 8];
        assign bad[d] = b > 8'd242;
        for (genvar k = 0; k < 5; k++) begin : g_trit
            if (5*d + k < EFFTRITS) begin : g_keep
                localparam int P = 3**k;
                logic [1:0] q;
                assign q = 2'((b / 8'(P)) % 8'd3);
                assign dec_trits[2*(5*d+k) +: 2] = bad[d] ? 2'b00 : {q[1], q[1] | q[0]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= 1'b0;
            tag_q    <= '0;
            count    <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            err_q    <= 1'b0;
            wc_q     <= '0;
        end else if (bus.flush_i) begin
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            err_q    <= 1'b0;
            wc_q     <= '0;
        end else begin
            inflight <= accept;
            if (accept) tag_q <= bus.rd_tag_i;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                wc_q   <= wc_q + 16'd1;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            err_q <= err_q | (push & |bad);
        end
    end

    // Payload storage needs no reset: outputs are gated by out_valid_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            trits_mem[wr_ptr] <= dec_trits;
            tag_mem[wr_ptr]   <= tag_q;
        end
    end
endmodule

// File: tb/tb_weightmemory_decode_stage.sv
// tb_weightmemory_decode_stage: scoreboard bench for the decode stage with N_I=40, WEIGHT_STAGGER=8 (one decoder, 5 trits).
module tb_weightmemory_decode_stage;
    localparam int N_I = 40, WS = 8, TAGW = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    weightmemory_decode_stage_if #(.N_I(N_I), .WEIGHT_STAGGER(WS), .TAGW(TAGW)) bus ();
    weightmemory_decode_stage #(.N_I(N_I), .WEIGHT_STAGGER(WS), .TAGW(TAGW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    typedef struct packed { logic [9:0] trits; logic [7:0] tag; } exp_t;
    exp_t        q[$];
    int          passed = 0, total = 0, m_acc = 0;
    logic        m_inf = 0, m_err = 0;
    logic [7:0]  m_tag = 0, mem_q = 0;
    logic [15:0] m_wc = 0;
    string       ctx = "init";

    function automatic logic [9:0] model_dec(input logic [7:0] b);
        int v = int'(b);
        logic [9:0] t = '0;
        if (b > 8'd242) return '0;
        for (int k = 0; k < 5; k++) begin
            if (v % 3 == 1) t[2*k +: 2] = 2'b01;
            if (v % 3 == 2) t[2*k +: 2] = 2'b11;
            v = v / 3;
        end
        return t;
    endfunction

    task automatic model_reset();
        q.delete();
        m_inf = 0; m_err = 0; m_wc = 0; mem_q = 0; m_tag = 0;
    endtask

    // One clock cycle: drive, scoreboard the outputs mid-cycle, then advance the reference model.
    task automatic step(input logic rd, input logic [7:0] tag, input logic [7:0] data,
                        input logic ordy, input logic fl);
        logic exp_rdy, acc, pop;
        bus.rd_en_i = rd; bus.rd_tag_i = tag; bus.out_ready_i = ordy;
        bus.flush_i = fl; bus.mem_rdata_i = mem_q;
        #3;
        exp_rdy = (q.size() + int'(m_inf)) < 2;
        total++;
        if (bus.out_valid_o !== logic'(q.size() > 0))
            $display("FAIL %s out_valid: got %b want %b", ctx, bus.out_valid_o, q.size() > 0);
        else passed++;
        if (q.size() > 0) begin
            total++;
            if ({bus.out_trits_o, bus.out_tag_o} !== q[0])
                $display("FAIL %s word: got trits %b tag %h want trits %b tag %h",
                         ctx, bus.out_trits_o, bus.out_tag_o, q[0].trits, q[0].tag);
            else passed++;
        end
        total++;
        if (bus.in_ready_o !== exp_rdy)
            $display("FAIL %s in_ready: got %b want %b", ctx, bus.in_ready_o, exp_rdy);
        else passed++;
        total++;
        if (bus.word_count_o !== m_wc)
            $display("FAIL %s word_count: got %0d want %0d", ctx, bus.word_count_o, m_wc);
        else passed++;
        total++;
        if (bus.decode_err_o !== m_err)
            $display("FAIL %s decode_err: got %b want %b", ctx, bus.decode_err_o, m_err);
        else passed++;
        acc = rd & exp_rdy & ~fl;
        pop = (q.size() > 0) & ordy;
        @(posedge clk); #1;
        if (fl) begin
            q.delete(); m_inf = 0; m_wc = 0; m_err = 0;
        end else begin
            if (pop) begin void'(q.pop_front()); m_wc++; end
            if (m_inf) begin
                q.push_back({model_dec(mem_q), m_tag});
                m_err |= (mem_q > 8'd242);
            end
            m_inf = acc;
            if (acc) begin m_tag = tag; m_acc++; end
        end
        mem_q = data;
    endtask

    task automatic test_reset();
        ctx = "reset";
        bus.rd_en_i = 0; bus.rd_tag_i = 0; bus.out_ready_i = 0; bus.flush_i = 0; bus.mem_rdata_i = 0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus.out_valid_o); else passed++;
        total++; if (bus.out_trits_o !== '0) $display("FAIL reset out_trits: got %b want 0", bus.out_trits_o); else passed++;
        total++; if (bus.out_tag_o !== '0) $display("FAIL reset out_tag: got %h want 0", bus.out_tag_o); else passed++;
        total++; if (bus.word_count_o !== '0) $display("FAIL reset word_count: got %0d want 0", bus.word_count_o); else passed++;
        total++; if (bus.decode_err_o !== 1'b0) $display("FAIL reset decode_err: got %b want 0", bus.decode_err_o); else passed++;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        #1;
        total++; if (bus.in_ready_o !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus.in_ready_o); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        ctx = "decode";
        step(1, 8'h11, 8'h05, 1, 0);
        step(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (bus.out_valid_o !== 1'b1 || bus.out_trits_o !== 10'b00_00_00_01_11 || bus.out_tag_o !== 8'h11)
            $display("FAIL decode 0x05: got v%b trits %b tag %h want v1 trits 0000000111 tag 11",
                     bus.out_valid_o, bus.out_trits_o, bus.out_tag_o);
        else passed++;
        step(0, 8'h00, 8'h00, 1, 0);
        step(0, 8'h00, 8'h00, 1, 0);
    endtask

    task automatic test_bounds();
        ctx = "bounds";
        step(1, 8'h21, 8'hF2, 1, 0);
        step(1, 8'h22, 8'hF3, 1, 0);
        total++;
        if (bus.out_trits_o !== 10'h3FF) $display("FAIL bounds 0xF2: got %b want 1111111111", bus.out_trits_o);
        else passed++;
        step(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (bus.out_trits_o !== 10'h000 || bus.decode_err_o !== 1'b1)
            $display("FAIL bounds 0xF3: got trits %b err %b want 0 and 1", bus.out_trits_o, bus.decode_err_o);
        else passed++;
        repeat (3) step(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (bus.decode_err_o !== 1'b1) $display("FAIL bounds sticky err: got %b want 1", bus.decode_err_o);
        else passed++;
        step(0, 8'h00, 8'h00, 1, 1);
        total++;
        if (bus.decode_err_o !== 1'b0) $display("FAIL bounds err flush: got %b want 0", bus.decode_err_o);
        else passed++;
    endtask

    task automatic test_backpressure();
        ctx = "backpressure";
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 8'h10 + 8'(i), 0, 0);
        total++;
        if (bus.in_ready_o !== 1'b0) $display("FAIL backpressure in_ready: got %b want 0", bus.in_ready_o);
        else passed++;
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (bus.word_count_o !== 16'd2) $display("FAIL backpressure count: got %0d want 2", bus.word_count_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int start_acc;
        ctx = "back_to_back";
        step(0, 8'h00, 8'h00, 1, 1);
        start_acc = m_acc;
        for (int i = 0; i < 20; i++) step(1, 8'(i), 8'($urandom_range(0, 242)), 1, 0);
        repeat (4) step(0, 8'h00, 8'h00, 1, 0);
        total++;
        if (int'(bus.word_count_o) !== m_acc - start_acc || bus.out_valid_o !== 1'b0)
            $display("FAIL back_to_back drain: got count %0d valid %b want %0d and 0",
                     bus.word_count_o, bus.out_valid_o, m_acc - start_acc);
        else passed++;
    endtask

    task automatic test_flush();
        ctx = "flush";
        step(1, 8'h51, 8'h0A, 0, 0);
        step(1, 8'h52, 8'h0B, 0, 0);
        step(0, 8'h00, 8'h00, 0, 1);
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.word_count_o !== 16'd0)
            $display("FAIL flush state: got v%b r%b c%0d want v0 r1 c0",
                     bus.out_valid_o, bus.in_ready_o, bus.word_count_o);
        else passed++;
        repeat (3) step(0, 8'h00, 8'h00, 1, 0);
    endtask

    task automatic test_reset_mid();
        ctx = "reset_mid";
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 8'h20 + 8'(i), 0, 0);
        step(0, 8'h00, 8'h00, 0, 0);
        bus.rd_en_i = 0;
        rst_n = 0;
        #1;
        total++;
        if (bus.out_valid_o !== 1'b0 || bus.out_trits_o !== '0 || bus.out_tag_o !== '0 ||
            bus.word_count_o !== '0 || bus.decode_err_o !== 1'b0)
            $display("FAIL reset_mid outputs: got v%b t%b g%h c%0d e%b want all 0", bus.out_valid_o,
                     bus.out_trits_o, bus.out_tag_o, bus.word_count_o, bus.decode_err_o);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        repeat (3) step(0, 8'h00, 8'h00, 1, 0);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_bounds();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
